// File: rtl/axil_master_cmd.sv
// AXI4-Lite single-outstanding master behind a valid/ready command port.
// Define AXIL_TIMEOUT_EN to abort stalled transfers after TIMEOUT_CYCLES.
module axil_master_cmd #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                aclk,
    input  logic                areset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic                busy,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_D, WR_AW, WR_B, RESP
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                aw_done;
    logic                w_done;
    logic                aw_hs;
    logic                w_hs;
    logic                wr_all;
    logic                step;
    logic                in_wait;
    logic                expired;
    logic                abort;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;

`ifdef AXIL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tcnt;

    assign expired = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Saturates so a late handshake at expiry cannot restart the window.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            tcnt <= '0;
        end else if (state == IDLE) begin
            tcnt <= '0;
        end else if (!expired) begin
            tcnt <= tcnt + CNT_W'(1);
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        aw_hs   = awvalid & awready;
        w_hs    = wvalid & wready;
        wr_all  = (aw_done | aw_hs) & (w_done | w_hs);
        step    = 1'b0;
        in_wait = 1'b1;
        unique case (state)
            RD_A:    step = arready;
            RD_D:    step = rvalid;
            WR_AW:   step = wr_all;
            WR_B:    step = bvalid;
            default: in_wait = 1'b0;
        endcase
        // A handshake on the expiry cycle wins over the abort.
        abort = expired & in_wait & ~step;
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (abort) begin
                arvalid     <= 1'b0;
                rready      <= 1'b0;
                awvalid     <= 1'b0;
                wvalid      <= 1'b0;
                bready      <= 1'b0;
                rsp_rdata   <= '0;
                rsp_resp    <= 2'b10;
                rsp_timeout <= 1'b1;
                rsp_valid   <= 1'b1;
                state       <= RESP;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            addr_q      <= cmd_addr;
                            wdata_q     <= cmd_wdata;
                            wstrb_q     <= cmd_wstrb;
                            rsp_rdata   <= '0;
                            rsp_resp    <= 2'b00;
                            rsp_timeout <= 1'b0;
                            if (cmd_write) begin
                                awvalid <= 1'b1;
                                wvalid  <= 1'b1;
                                aw_done <= 1'b0;
                                w_done  <= 1'b0;
                                state   <= WR_AW;
                            end else begin
                                arvalid <= 1'b1;
                                state   <= RD_A;
                            end
                        end
                    end
                    RD_A: begin
                        if (arready) begin
                            arvalid <= 1'b0;
                            rready  <= 1'b1;
                            state   <= RD_D;
                        end
                    end
                    RD_D: begin
                        if (rvalid) begin
                            rready    <= 1'b0;
                            rsp_rdata <= rdata;
                            rsp_resp  <= rresp;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                    WR_AW: begin
                        if (aw_hs) begin
                            awvalid <= 1'b0;
                            aw_done <= 1'b1;
                        end
                        if (w_hs) begin
                            wvalid <= 1'b0;
                            w_done <= 1'b1;
                        end
                        if (wr_all) begin
                            bready <= 1'b1;
                            state  <= WR_B;
                        end
                    end
                    WR_B: begin
                        if (bvalid) begin
                            bready    <= 1'b0;
                            rsp_resp  <= bresp;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                    RESP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axil_master_cmd.sv
// Scoreboard bench for axil_master_cmd with a delay-programmable AXI-Lite slave.
// The AXIL_TIMEOUT_EN build also exercises the abort path with TIMEOUT_CYCLES=16.
module tb_axil_master_cmd;
`ifdef AXIL_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 256;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [1:0]  bresp = 0, rresp = 0;
    logic [31:0] rdata = 0;

    axil_master_cmd #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    int   cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int   errors = 0, checks = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave knobs and captured channel contents
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    bit          r_hold = 0;
    logic [31:0] rdata_v = 0;
    logic [1:0]  rresp_v = 0, bresp_v = 0;
    logic [31:0] cap_araddr = 0, cap_awaddr = 0, cap_wdata = 0;
    logic [3:0]  cap_wstrb = 0;

    initial begin
        logic        s_arv, s_rr, s_awv, s_wv, s_br;
        logic [31:0] s_araddr, s_awaddr, s_wdata;
        logic [3:0]  s_wstrb;
        int          ar_c, aw_c, w_c;
        bit          r_pend, b_pend, aw_got, w_got;
        {s_arv, s_rr, s_awv, s_wv, s_br} = '0;
        {ar_c, aw_c, w_c} = '0;
        {r_pend, b_pend, aw_got, w_got} = '0;
        s_araddr = 0; s_awaddr = 0; s_wdata = 0; s_wstrb = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (!areset_n) begin
                {s_arv, s_rr, s_awv, s_wv, s_br} = '0;
                {ar_c, aw_c, w_c} = '0;
                {r_pend, b_pend, aw_got, w_got} = '0;
                {arready, rvalid, awready, wready, bvalid} = '0;
            end else begin
                if (s_arv && arready) begin
                    r_pend = 1; ar_c = 0; cap_araddr = s_araddr;
                end
                if (rvalid && s_rr) r_pend = 0;
                if (s_awv && awready) begin
                    aw_got = 1; aw_c = 0; cap_awaddr = s_awaddr;
                end
                if (s_wv && wready) begin
                    w_got = 1; w_c = 0; cap_wdata = s_wdata; cap_wstrb = s_wstrb;
                end
                if (bvalid && s_br) b_pend = 0;
                if (aw_got && w_got) begin
                    b_pend = 1; aw_got = 0; w_got = 0;
                end
                s_arv = arvalid; s_rr = rready; s_awv = awvalid;
                s_wv = wvalid; s_br = bready;
                s_araddr = araddr; s_awaddr = awaddr;
                s_wdata = wdata; s_wstrb = wstrb;
                arready = arvalid && (ar_c >= ar_delay);
                if (arvalid && !arready) ar_c++;
                awready = awvalid && (aw_c >= aw_delay);
                if (awvalid && !awready) aw_c++;
                wready = wvalid && (w_c >= w_delay);
                if (wvalid && !wready) w_c++;
                rvalid = r_pend && !r_hold;
                rdata  = r_pend ? rdata_v : 32'h0;
                rresp  = rresp_v;
                bvalid = b_pend;
                bresp  = bresp_v;
            end
        end
    end

    // Monitor: scoreboard pops, channel activity counters, stability
    int          rsp_n = 0, rsp_cyc = 0, ar_hi = 0, aw_hi = 0, w_hi = 0, ar_hs_n = 0;
    int          stab_err = 0;
    bit          b_early = 0, b_seen = 0;
    initial begin
        logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [3:0]  p_wstrb;
        exp_t        e;
        {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr} = '0;
        p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
        forever begin
            @(negedge aclk);
            if (!areset_n) begin
                {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr} = '0;
            end else begin
                if (!rsp_valid) begin
                    if (p_arv && !p_arr && !(arvalid && araddr == p_araddr))
                        stab_err++;
                    if (p_awv && !p_awr && !(awvalid && awaddr == p_awaddr))
                        stab_err++;
                    if (p_wv && !p_wr &&
                        !(wvalid && wdata == p_wdata && wstrb == p_wstrb))
                        stab_err++;
                end
                if (arvalid) ar_hi++;
                if (awvalid) aw_hi++;
                if (wvalid) w_hi++;
                if (arvalid && arready) ar_hs_n++;
                if (bready) b_seen = 1;
                if (bready && (awvalid || wvalid)) b_early = 1;
                if (rsp_valid) begin
                    rsp_n++;
                    rsp_cyc = cyc;
                    chk("rsp_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1 required none");
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                        chk("rsp_resp", {62'd0, rsp_resp}, {62'd0, e.resp});
                        chk("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, e.to});
                    end
                end
                p_arv = arvalid; p_arr = arready; p_awv = awvalid; p_awr = awready;
                p_wv = wvalid; p_wr = wready;
                p_araddr = araddr; p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb;
            end
        end
    end

    int acc_cyc = 0;

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit push, input exp_t e);
        int n = 0;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(posedge aclk); #1; n++;
        end
        chk("cmd_accept", {63'd0, cmd_ready}, 64'd1);
        acc_cyc = cyc;
        if (push) sb.push_back(e);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int count0, input string name);
        int n = 0;
        while (rsp_n == count0 && n < 100) begin
            @(negedge aclk); n++;
        end
        chk(name, {63'd0, rsp_n != count0}, 64'd1);
    endtask

    task automatic clr_cnt();
        ar_hi = 0; aw_hi = 0; w_hi = 0; ar_hs_n = 0; b_early = 0; b_seen = 0;
    endtask

    initial begin
        exp_t e;
        int   r0, a0, acc;
        logic [7:0] vec;

        repeat (3) @(posedge aclk);
        #1;
        vec = {arvalid, awvalid, wvalid, rready, bready, rsp_valid, busy, cmd_ready};
        chk("reset_outputs", {56'd0, vec}, 64'h01);
        chk("reset_rsp_fields", {29'd0, rsp_rdata, rsp_resp, rsp_timeout}, 64'd0);
        areset_n = 1'b1;
        @(posedge aclk); #1;

        // Read, zero-wait slave
        clr_cnt();
        rdata_v = 32'hDEADBEEF; rresp_v = 2'b00;
        r0 = rsp_n;
        e = '{32'hDEADBEEF, 2'b00, 1'b0};
        issue(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, e);
        a0 = acc_cyc;
        wait_rsp(r0, "rd_rsp_seen");
        chk("rd_latency", 64'(rsp_cyc - a0), 64'd3);
        @(posedge aclk); #1;
        chk("rd_next_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rd_arvalid_cycles", 64'(ar_hi), 64'd1);
        chk("rd_araddr", {32'd0, cap_araddr}, 64'h8);

        // Write with delayed AW, immediate W
        clr_cnt();
        aw_delay = 3; bresp_v = 2'b00;
        r0 = rsp_n;
        e = '{32'h0, 2'b00, 1'b0};
        issue(1'b1, 32'h4, 32'h0000_00A5, 4'h1, 1'b1, e);
        wait_rsp(r0, "wr_rsp_seen");
        chk("wr_awvalid_cycles", 64'(aw_hi), 64'd4);
        chk("wr_wvalid_cycles", 64'(w_hi), 64'd1);
        chk("wr_bready_order", {62'd0, b_seen, b_early}, 64'b10);
        chk("wr_awaddr", {32'd0, cap_awaddr}, 64'h4);
        chk("wr_wdata_strb", {28'd0, cap_wdata, cap_wstrb}, {28'd0, 32'hA5, 4'h1});
        aw_delay = 0;
        @(posedge aclk); #1;

        // SLVERR write then back-to-back read with DECERR
        bresp_v = 2'b10; rresp_v = 2'b11; rdata_v = 32'h1234_5678;
        r0 = rsp_n;
        e = '{32'h0, 2'b10, 1'b0};
        issue(1'b1, 32'h20, 32'hCAFE_0001, 4'hF, 1'b1, e);
        a0 = acc_cyc;
        e = '{32'h1234_5678, 2'b11, 1'b0};
        issue(1'b0, 32'h24, 32'h0, 4'h0, 1'b1, e);
        chk("b2b_accept_gap", 64'(acc_cyc - a0), 64'd4);
        wait_rsp(r0 + 1, "b2b_rsp_seen");
        chk("b2b_rsp_count", 64'(rsp_n - r0), 64'd2);
        bresp_v = 2'b00; rresp_v = 2'b00;
        @(posedge aclk); #1;

        // cmd_valid held high across busy periods
        clr_cnt();
        rdata_v = 32'h0BAD_F00D;
        e = '{32'h0BAD_F00D, 2'b00, 1'b0};
        cmd_write = 1'b0; cmd_addr = 32'h10; cmd_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (cmd_ready) begin
                acc++;
                sb.push_back(e);
            end
            @(posedge aclk); #1;
        end
        cmd_valid = 1'b0;
        repeat (6) @(posedge aclk);
        #1;
        chk("held_accepts", 64'(acc), 64'd3);
        chk("held_ar_handshakes", 64'(ar_hs_n), 64'd3);
        chk("held_sb_drained", 64'(sb.size()), 64'd0);

        // Reset while waiting in RD_D
        r_hold = 1;
        e = '{32'h0, 2'b00, 1'b0};
        issue(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, e);
        for (int i = 0; i < 20 && !rready; i++) begin
            @(posedge aclk); #1;
        end
        chk("rst_in_rd_d", {63'd0, rready}, 64'd1);
        r0 = rsp_n;
        areset_n = 1'b0;
        @(posedge aclk); #1;
        vec = {arvalid, awvalid, wvalid, rready, bready, rsp_valid, busy, cmd_ready};
        chk("rst_mid_outputs", {56'd0, vec}, 64'h01);
        @(posedge aclk); #2;
        areset_n = 1'b1;
        r_hold = 0;
        repeat (8) @(posedge aclk);
        #1;
        chk("rst_no_rsp", 64'(rsp_n - r0), 64'd0);

`ifdef AXIL_TIMEOUT_EN
        // Read against a slave that never raises arready
        clr_cnt();
        ar_delay = 1000;
        r0 = rsp_n;
        e = '{32'h0, 2'b10, 1'b1};
        issue(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, e);
        wait_rsp(r0, "to_rsp_seen");
        chk("to_arvalid_cycles", 64'(ar_hi), 64'd16);
        ar_delay = 0;
        @(posedge aclk); #1;
`endif

        repeat (4) @(posedge aclk);
        #1;
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        chk("axi_stability", 64'(stab_err), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required $finish before 200000");
        $fatal(1);
    end
endmodule
